ir_scan_sequencer: RTL

Sequences the servo/IR sensing datapath for a full angular scan. The block steps the servo angle from `ANGLE_MIN` to `ANGLE_MAX`, waits for mechanical settling, and requests one IR range sample per position. It then writes each sample into cell memory through a request/grant port on the memory manager's core-side port. It sits in `core_top` between the servo PWM generator, the IR sensor decoder, and the memory arbiter.

---
 rtl/scan_pkg.sv | 24 ++
 rtl/cycle_timer.sv | 31 +++
 rtl/ir_scan_sequencer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/scan_pkg.sv
// Shared types and widths for the servo/IR angular scan sequencer.
package scan_pkg;

    localparam int ANGLE_W = 16;
    localparam int ADDR_W  = 24;
    localparam int DATA_W  = 16;

    // Sample value written when the IR sensor never answers.
    localparam logic [DATA_W-1:0] IR_TIMEOUT_CODE = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_WRITE,
        ST_NEXT
    } scan_state_t;

    // Counter width able to hold 0 .. limit-1.
    function automatic int timer_width(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Up-counter that flags the LIMIT-th consecutive counting cycle since the last load.
module cycle_timer
    import scan_pkg::*;
#(
    parameter int LIMIT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic count,
    output logic expire
);

    localparam int W = timer_width(LIMIT);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] count_reg;

    assign expire = count && (count_reg == LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= '0;
        end else if (count && !expire) begin
            count_reg <= count_reg + W'(1);
        end
    end

endmodule

// File: rtl/ir_scan_sequencer.sv
// Steps the servo across ANGLE_MIN..ANGLE_MAX, takes one IR sample per position and writes it to memory.
// Optional IR ack timeout is compiled in with IR_SCAN_TIMEOUT_EN.
module ir_scan_sequencer
    import scan_pkg::*;
#(
    parameter int                ANGLE_MIN      = 0,
    parameter int                ANGLE_MAX      = 180,
    parameter int                ANGLE_STEP     = 15,
    parameter int                SETTLE_CYCLES  = 25_000_000,
    parameter int                TIMEOUT_CYCLES = 5_000_000,
    parameter logic [ADDR_W-1:0] BASE_ADDR      = 24'h001000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               continuous,
    output logic [ANGLE_W-1:0] angle,
    output logic               ir_req,
    input  logic               ir_ack,
    input  logic [DATA_W-1:0]  ir_data,
    output logic               mem_req,
    input  logic               mem_gnt,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    output logic               mem_we,
    output logic               busy,
    output logic               done,
    output logic [7:0]         sample_idx,
    output logic               ir_err
);

    localparam logic [ANGLE_W-1:0] ANGLE_MIN_V = ANGLE_W'(ANGLE_MIN);
    localparam logic [ANGLE_W-1:0] ANGLE_MAX_V = ANGLE_W'(ANGLE_MAX);
    localparam logic [ANGLE_W:0]   STEP_V      = (ANGLE_W + 1)'(ANGLE_STEP);
    localparam int NUM_POS = (ANGLE_STEP >= 1)
                           ? (ANGLE_MAX - ANGLE_MIN + ANGLE_STEP - 1) / ANGLE_STEP + 1 : 1;

    // Reject parameter sets the sequencer cannot scan correctly.
    if (ANGLE_MAX < ANGLE_MIN) begin : g_bad_range
        $error("ir_scan_sequencer: ANGLE_MAX must be >= ANGLE_MIN");
    end
    if (ANGLE_STEP < 1) begin : g_bad_step
        $error("ir_scan_sequencer: ANGLE_STEP must be >= 1");
    end
    if (SETTLE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_timer
        $error("ir_scan_sequencer: timer lengths must be >= 1");
    end
    if (NUM_POS > 256) begin : g_bad_count
        $error("ir_scan_sequencer: more than 256 scan positions");
    end

    scan_state_t        state_reg, state_next;
    logic [ANGLE_W-1:0] angle_reg, angle_next;
    logic [7:0]         idx_reg, idx_next;
    logic [DATA_W-1:0]  wdata_reg, wdata_next;
    logic [ADDR_W-1:0]  addr_reg;
    logic               ir_req_reg;
    logic               mem_req_reg;
    logic               busy_reg;
    logic               done_reg, done_next;

    logic               in_settle;
    logic               settle_expire;
    logic               at_max;
    logic [ANGLE_W:0]   angle_sum;
    logic [ANGLE_W-1:0] angle_clamped;

    assign in_settle = (state_reg == ST_SETTLE);
    assign at_max    = (angle_reg == ANGLE_MAX_V);

    // Sum one bit wider so the step past ANGLE_MAX cannot wrap before the clamp.
    assign angle_sum     = {1'b0, angle_reg} + STEP_V;
    assign angle_clamped = (angle_sum > {1'b0, ANGLE_MAX_V}) ? ANGLE_MAX_V : angle_sum[ANGLE_W-1:0];

    cycle_timer #(
        .LIMIT (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (!in_settle),
        .count  (in_settle),
        .expire (settle_expire)
    );

`ifdef IR_SCAN_TIMEOUT_EN
    logic in_sample;
    logic timeout_expire;
    logic err_set;
    logic ir_err_reg;

    assign in_sample = (state_reg == ST_SAMPLE);

    cycle_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (!in_sample),
        .count  (in_sample),
        .expire (timeout_expire)
    );

    assign err_set = in_sample && !ir_ack && timeout_expire;

    // Sticky until the next accepted start.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ir_err_reg <= 1'b0;
        end else if (state_reg == ST_IDLE && start) begin
            ir_err_reg <= 1'b0;
        end else if (err_set) begin
            ir_err_reg <= 1'b1;
        end
    end

    assign ir_err = ir_err_reg;
`else
    assign ir_err = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        angle_next = angle_reg;
        idx_next   = idx_reg;
        wdata_next = wdata_reg;
        done_next  = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                angle_next = ANGLE_MIN_V;
                idx_next   = 8'd0;
                if (start) begin
                    state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_expire) begin
                    state_next = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (ir_ack) begin
                    wdata_next = ir_data;
                    state_next = ST_WRITE;
                end
`ifdef IR_SCAN_TIMEOUT_EN
                else if (timeout_expire) begin
                    wdata_next = IR_TIMEOUT_CODE;
                    state_next = ST_WRITE;
                end
`endif
            end
            ST_WRITE: begin
                // done is raised here so it lands in the NEXT cycle right after the final grant.
                if (mem_req_reg && mem_gnt) begin
                    state_next = ST_NEXT;
                    done_next  = at_max;
                end
            end
            ST_NEXT: begin
                if (at_max) begin
                    angle_next = ANGLE_MIN_V;
                    idx_next   = 8'd0;
                    state_next = continuous ? ST_SETTLE : ST_IDLE;
                end else begin
                    angle_next = angle_clamped;
                    idx_next   = idx_reg + 8'd1;
                    state_next = ST_SETTLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from next-state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            angle_reg   <= ANGLE_MIN_V;
            idx_reg     <= 8'd0;
            wdata_reg   <= '0;
            addr_reg    <= BASE_ADDR;
            ir_req_reg  <= 1'b0;
            mem_req_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            angle_reg   <= angle_next;
            idx_reg     <= idx_next;
            wdata_reg   <= wdata_next;
            addr_reg    <= BASE_ADDR + ADDR_W'(idx_next);
            ir_req_reg  <= (state_next == ST_SAMPLE);
            mem_req_reg <= (state_next == ST_WRITE);
            busy_reg    <= (state_next != ST_IDLE);
            done_reg    <= done_next;
        end
    end

    assign angle      = angle_reg;
    assign sample_idx = idx_reg;
    assign ir_req     = ir_req_reg;
    assign mem_req    = mem_req_reg;
    assign mem_we     = mem_req_reg;
    assign mem_addr   = addr_reg;
    assign mem_wdata  = wdata_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;

endmodule
